// File: rtl/kbd_pkg.sv
// kbd_pkg -- shared definitions for the keyboard command decoder.
//   * PS/2 set-2 scancode constants for every key the decoder reacts to
//   * decoder state enum
//   * scan_to_bcd(): maps a digit scancode to its BCD value plus a valid flag
package kbd_pkg;

   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_H     = 8'h33;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_P     = 8'h4D;
   localparam logic [7:0] SC_G     = 8'h34;
   localparam logic [7:0] SC_Y     = 8'h35;
   localparam logic [7:0] SC_N     = 8'h31;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CH_SEL,
      ST_DIGIT,
      ST_H_SEL,
      ST_G_SEL
   } state_t;

   typedef struct packed {
      logic       vld;
      logic [3:0] dig;
   } bcd_t;

   function automatic bcd_t scan_to_bcd(input logic [7:0] sc);
      bcd_t r;
      r.vld = 1'b1;
      r.dig = 4'd0;
      case (sc)
         8'h45:   r.dig = 4'd0;
         8'h16:   r.dig = 4'd1;
         8'h1E:   r.dig = 4'd2;
         8'h26:   r.dig = 4'd3;
         8'h25:   r.dig = 4'd4;
         8'h2E:   r.dig = 4'd5;
         8'h36:   r.dig = 4'd6;
         8'h3D:   r.dig = 4'd7;
         8'h3E:   r.dig = 4'd8;
         8'h46:   r.dig = 4'd9;
         default: r.vld = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/kbd_timeout.sv
// kbd_timeout -- idle-command watchdog counter.
//   CLK     in  rising-edge clock
//   RST_N   in  asynchronous active-low reset (counter reloads)
//   load    in  reload the counter to TIMEOUT_CYC
//   enable  in  count down while high
//   tc      out terminal count: high in the cycle whose edge completes
//               TIMEOUT_CYC enabled cycles since the last load
module kbd_timeout #(
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic load,
   input  logic enable,
   output logic tc
);

   localparam int            CW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= RELOAD;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Fires on the last enabled cycle, so the owner acts on the same edge
   // that would take the count to zero.
   assign tc = enable && (cnt == CW'(1));

endmodule

// File: rtl/kbd_cmd_decoder.sv
// kbd_cmd_decoder -- turns a stream of PS/2 set-2 scancodes into setpoint,
// alarm and gas-enable commands.
//   CLK          in  rising-edge clock
//   RST_N        in  asynchronous active-low reset
//   code_valid   in  one-cycle strobe, code is valid
//   code[7:0]    in  scancode byte
//   value        out packed BCD setpoints, channel 0 in the LSBs,
//                    most significant digit first within a channel
//   value_upd    out one-cycle pulse, coincident with a setpoint change
//   value_ch     out channel index of the last commit
//   alarm_level  out 00 none, 01 alert, 10 danger
//   gas_en       out gas-sensor enable
//   sw_reset     out one-cycle pulse on the R key
//   err          out one-cycle pulse on an invalid key or a timeout
//   busy         out high whenever a command is open
module kbd_cmd_decoder
   import kbd_pkg::*;
#(
   parameter int NCH         = 2,
   parameter int NDIG        = 2,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   code_valid,
   input  logic [7:0]             code,
   output logic [NCH*NDIG*4-1:0]  value,
   output logic                   value_upd,
   output logic [3:0]             value_ch,
   output logic [1:0]             alarm_level,
   output logic                   gas_en,
   output logic                   sw_reset,
   output logic                   err,
   output logic                   busy
);

   localparam int         CHW  = NDIG * 4;
   localparam int         VW   = NCH * CHW;
   localparam int         DCW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [3:0] NCH4 = 4'(NCH);

   state_t           state_q, state_d;
   logic [VW-1:0]    value_q, value_d;
   logic             upd_q, upd_d;
   logic [3:0]       vch_q, vch_d;
   logic [1:0]       alarm_q, alarm_d;
   logic             gas_q, gas_d;
   logic             swr_q, swr_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic             brk_q, brk_d;
   logic [CHW-1:0]   stage_q, stage_d;
   logic [DCW-1:0]   dcnt_q, dcnt_d;
   logic [3:0]       sel_q, sel_d;

   logic             tc;
   logic             key_ok;
   bcd_t             bcd;
   logic [CHW-1:0]   new_stage;

   kbd_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .load   (code_valid),
      .enable (state_q != ST_IDLE),
      .tc     (tc)
   );

   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      upd_d     = 1'b0;
      vch_d     = vch_q;
      alarm_d   = alarm_q;
      gas_d     = gas_q;
      swr_d     = 1'b0;
      err_d     = 1'b0;
      brk_d     = brk_q;
      stage_d   = stage_q;
      dcnt_d    = dcnt_q;
      sel_d     = sel_q;

      bcd       = scan_to_bcd(code);
      // Staging shifts left: the first digit typed ends up most significant.
      new_stage = CHW'({stage_q, bcd.dig});

      // Byte after F0 is a key release; E0 is a bare prefix with no effect.
      key_ok = code_valid && !brk_q && (code != SC_BREAK) && (code != SC_EXT);

      if (code_valid) begin
         if (brk_q) begin
            brk_d = 1'b0;
         end else if (code == SC_BREAK) begin
            brk_d = 1'b1;
         end
      end

      if (key_ok) begin
         if (code == SC_R) begin
            swr_d   = 1'b1;
            alarm_d = 2'b00;
            gas_d   = 1'b0;
            stage_d = '0;
            dcnt_d  = '0;
            state_d = ST_IDLE;
         end else if ((code == SC_ESC) && (state_q != ST_IDLE)) begin
            stage_d = '0;
            dcnt_d  = '0;
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (code == SC_ENTER) begin
                     state_d = ST_CH_SEL;
                  end else if (code == SC_H) begin
                     state_d = ST_H_SEL;
                  end else if (code == SC_G) begin
                     state_d = ST_G_SEL;
                  end
               end
               ST_CH_SEL: begin
                  if (bcd.vld && (bcd.dig != 4'd0) && (bcd.dig <= NCH4)) begin
                     sel_d   = bcd.dig - 4'd1;
                     stage_d = '0;
                     dcnt_d  = '0;
                     state_d = ST_DIGIT;
                  end else begin
                     err_d   = 1'b1;
                     state_d = ST_IDLE;
                  end
               end
               ST_DIGIT: begin
                  if (bcd.vld) begin
                     if (dcnt_q == DCW'(NDIG - 1)) begin
                        // Only the selected channel's slice is written.
                        for (int c = 0; c < NCH; c++) begin
                           if (sel_q == 4'(c)) begin
                              value_d[c*CHW +: CHW] = new_stage;
                           end
                        end
                        upd_d   = 1'b1;
                        vch_d   = sel_q;
                        stage_d = '0;
                        dcnt_d  = '0;
                        state_d = ST_IDLE;
                     end else begin
                        stage_d = new_stage;
                        dcnt_d  = dcnt_q + DCW'(1);
                     end
                  end else begin
                     err_d   = 1'b1;
                     stage_d = '0;
                     dcnt_d  = '0;
                     state_d = ST_IDLE;
                  end
               end
               ST_H_SEL: begin
                  if (code == SC_A) begin
                     alarm_d = 2'b01;
                  end else if (code == SC_P) begin
                     alarm_d = 2'b10;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = ST_IDLE;
               end
               ST_G_SEL: begin
                  if (code == SC_Y) begin
                     gas_d = 1'b1;
                  end else if (code == SC_N) begin
                     gas_d = 1'b0;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = ST_IDLE;
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end else if (!code_valid && tc) begin
         // A code arriving on the terminal-count cycle wins over the timeout.
         err_d   = 1'b1;
         stage_d = '0;
         dcnt_d  = '0;
         state_d = ST_IDLE;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         value_q <= '0;
         upd_q   <= 1'b0;
         vch_q   <= 4'd0;
         alarm_q <= 2'b00;
         gas_q   <= 1'b0;
         swr_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         brk_q   <= 1'b0;
         stage_q <= '0;
         dcnt_q  <= '0;
         sel_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         upd_q   <= upd_d;
         vch_q   <= vch_d;
         alarm_q <= alarm_d;
         gas_q   <= gas_d;
         swr_q   <= swr_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         brk_q   <= brk_d;
         stage_q <= stage_d;
         dcnt_q  <= dcnt_d;
         sel_q   <= sel_d;
      end
   end

   assign value       = value_q;
   assign value_upd   = upd_q;
   assign value_ch    = vch_q;
   assign alarm_level = alarm_q;
   assign gas_en      = gas_q;
   assign sw_reset    = swr_q;
   assign err         = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_kbd_cmd_decoder.sv
// tb_kbd_cmd_decoder -- directed vector table, hand-written multi-cycle
// sequences (timeout, async reset) and a randomized run against a
// queue-based command model.
module tb_kbd_cmd_decoder;

   localparam int NCH  = 2;
   localparam int NDIG = 2;
   localparam int TO   = 10;
   localparam int VW   = NCH * NDIG * 4;

   logic          CLK = 1'b0;
   logic          RST_N;
   logic          code_valid;
   logic [7:0]    code;
   logic [VW-1:0] value;
   logic          value_upd;
   logic [3:0]    value_ch;
   logic [1:0]    alarm_level;
   logic          gas_en;
   logic          sw_reset;
   logic          err;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   kbd_cmd_decoder #(
      .NCH         (NCH),
      .NDIG        (NDIG),
      .TIMEOUT_CYC (TO)
   ) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .code_valid  (code_valid),
      .code        (code),
      .value       (value),
      .value_upd   (value_upd),
      .value_ch    (value_ch),
      .alarm_level (alarm_level),
      .gas_en      (gas_en),
      .sw_reset    (sw_reset),
      .err         (err),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   // ---------------- reference model ----------------
   logic [7:0] dtab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
   logic [3:0] m_dig [NCH][NDIG];
   logic [7:0] pend [$];
   logic       m_upd, m_swr, m_err, m_gas, m_brk;
   logic [1:0] m_alarm;
   logic [3:0] m_ch;
   int         m_idle;

   function automatic int digit_of(input logic [7:0] c);
      for (int i = 0; i < 10; i++) if (dtab[i] == c) return i;
      return -1;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < NDIG; i++) m_dig[c][i] = 4'd0;
      pend.delete();
      m_upd = 0; m_swr = 0; m_err = 0; m_gas = 0; m_brk = 0;
      m_alarm = 2'b00; m_ch = 4'd0; m_idle = 0;
   endfunction

   function automatic logic [VW-1:0] m_value();
      logic [VW-1:0] r = '0;
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < NDIG; i++)
            r[c*NDIG*4 + (NDIG-1-i)*4 +: 4] = m_dig[c][i];
      return r;
   endfunction

   function automatic void model_key(input logic [7:0] c);
      int  d;
      int  ch;
      bit  ok;
      d = digit_of(c);
      if (c == 8'h2D) begin
         m_swr = 1; m_alarm = 2'b00; m_gas = 0; pend.delete();
         return;
      end
      if (pend.size() == 0) begin
         if (c == 8'h5A || c == 8'h33 || c == 8'h34) pend.push_back(c);
         return;
      end
      if (c == 8'h76) begin
         pend.delete();
         return;
      end
      if (pend[0] == 8'h33) begin
         if (c == 8'h1C) m_alarm = 2'b01;
         else if (c == 8'h4D) m_alarm = 2'b10;
         else m_err = 1;
         pend.delete();
      end else if (pend[0] == 8'h34) begin
         if (c == 8'h35) m_gas = 1;
         else if (c == 8'h31) m_gas = 0;
         else m_err = 1;
         pend.delete();
      end else begin
         if (pend.size() == 1) ok = (d >= 1) && (d <= NCH);
         else ok = (d >= 0);
         if (!ok) begin
            m_err = 1;
            pend.delete();
         end else begin
            pend.push_back(c);
            if (pend.size() == 2 + NDIG) begin
               ch = digit_of(pend[1]) - 1;
               for (int i = 0; i < NDIG; i++) m_dig[ch][i] = 4'(digit_of(pend[2+i]));
               m_upd = 1;
               m_ch  = 4'(ch);
               pend.delete();
            end
         end
      end
   endfunction

   function automatic void model_step(input logic v, input logic [7:0] c);
      m_upd = 0; m_swr = 0; m_err = 0;
      if (v) begin
         m_idle = 0;
         if (m_brk) m_brk = 0;
         else if (c == 8'hF0) m_brk = 1;
         else if (c != 8'hE0) model_key(c);
      end else if (pend.size() != 0) begin
         m_idle++;
         if (m_idle >= TO) begin
            m_err = 1;
            pend.delete();
         end
      end
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [VW-1:0] ev, input logic eupd,
                            input logic [3:0] ech, input logic [1:0] eal, input logic egas,
                            input logic eswr, input logic eerr, input logic ebusy);
      chk({tag, ".value"},     32'(value),       32'(ev));
      chk({tag, ".value_upd"}, 32'(value_upd),   32'(eupd));
      chk({tag, ".value_ch"},  32'(value_ch),    32'(ech));
      chk({tag, ".alarm"},     32'(alarm_level), 32'(eal));
      chk({tag, ".gas_en"},    32'(gas_en),      32'(egas));
      chk({tag, ".sw_reset"},  32'(sw_reset),    32'(eswr));
      chk({tag, ".err"},       32'(err),         32'(eerr));
      chk({tag, ".busy"},      32'(busy),        32'(ebusy));
   endtask

   task automatic check_model(input string tag);
      check_all(tag, m_value(), m_upd, m_ch, m_alarm, m_gas, m_swr, m_err, pend.size() != 0);
   endtask

   // Called at a negedge; drives one cycle and returns at the next negedge.
   task automatic tick(input logic v, input logic [7:0] c);
      code_valid = v;
      code       = c;
      @(posedge CLK);
      model_step(v, c);
      @(negedge CLK);
      code_valid = 1'b0;
      code       = 8'h00;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          vld;
      logic [7:0]    code;
      logic [VW-1:0] value;
      logic          upd;
      logic [3:0]    ch;
      logic [1:0]    al;
      logic          gas, swr, err, busy;
   } vec_t;

   vec_t tv [$];

   function automatic vec_t mkv(input logic v, input logic [7:0] c, input logic [VW-1:0] val,
                                input logic u, input logic [3:0] ch, input logic [1:0] al,
                                input logic g, input logic s, input logic e, input logic b);
      vec_t r;
      r.vld = v; r.code = c; r.value = val; r.upd = u; r.ch = ch;
      r.al = al; r.gas = g; r.swr = s; r.err = e; r.busy = b;
      return r;
   endfunction

   logic [7:0] pool [25] = '{8'h5A, 8'h5A, 8'h5A, 8'h2D, 8'h33, 8'h1C, 8'h4D, 8'h34, 8'h35,
                             8'h31, 8'h76, 8'hF0, 8'hE0, 8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h16, 8'h1E};

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       rv;
      logic [7:0] rc;

      // commit on channel 1: Enter,2,3,4
      tv.push_back(mkv(1, 8'h5A, 16'h0000, 0, 0, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h1E, 16'h0000, 0, 0, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h26, 16'h0000, 0, 0, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h25, 16'h3400, 1, 1, 2'd0, 0, 0, 0, 0));
      tv.push_back(mkv(0, 8'h00, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 0));
      // invalid key during digit entry
      tv.push_back(mkv(1, 8'h5A, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h16, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h1C, 16'h3400, 0, 1, 2'd0, 0, 0, 1, 0));
      tv.push_back(mkv(0, 8'h00, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 0));
      // break filtering: H,F0,33,P
      tv.push_back(mkv(1, 8'h33, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'hF0, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h33, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h4D, 16'h3400, 0, 1, 2'd2, 0, 0, 0, 0));
      // G,Y then R in the middle of digit entry
      tv.push_back(mkv(1, 8'h34, 16'h3400, 0, 1, 2'd2, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h35, 16'h3400, 0, 1, 2'd2, 1, 0, 0, 0));
      tv.push_back(mkv(1, 8'h5A, 16'h3400, 0, 1, 2'd2, 1, 0, 0, 1));
      tv.push_back(mkv(1, 8'h16, 16'h3400, 0, 1, 2'd2, 1, 0, 0, 1));
      tv.push_back(mkv(1, 8'h1E, 16'h3400, 0, 1, 2'd2, 1, 0, 0, 1));
      tv.push_back(mkv(1, 8'h2D, 16'h3400, 0, 1, 2'd0, 0, 1, 0, 0));
      tv.push_back(mkv(0, 8'h00, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 0));
      // commit on channel 0: Enter,1,0,9 leaves channel 1 intact
      tv.push_back(mkv(1, 8'h5A, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h16, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h45, 16'h3400, 0, 1, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h46, 16'h3409, 1, 0, 2'd0, 0, 0, 0, 0));
      // channel above NCH
      tv.push_back(mkv(1, 8'h5A, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h26, 16'h3409, 0, 0, 2'd0, 0, 0, 1, 0));
      // E0 prefix is transparent, Esc aborts silently, junk in IDLE ignored
      tv.push_back(mkv(1, 8'hE0, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 0));
      tv.push_back(mkv(1, 8'h5A, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h76, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 0));
      tv.push_back(mkv(1, 8'h1C, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 0));
      // channel 0 key is not a valid channel
      tv.push_back(mkv(1, 8'h5A, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 1));
      tv.push_back(mkv(1, 8'h45, 16'h3409, 0, 0, 2'd0, 0, 0, 1, 0));
      tv.push_back(mkv(0, 8'h00, 16'h3409, 0, 0, 2'd0, 0, 0, 0, 0));

      // reset state
      RST_N      = 1'b0;
      code_valid = 1'b0;
      code       = 8'h00;
      model_reset();
      #3;
      check_all("reset", '0, 0, 4'd0, 2'd0, 0, 0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      tick(0, 8'h00);
      check_all("reset_rel", '0, 0, 4'd0, 2'd0, 0, 0, 0, 0);

      for (int i = 0; i < tv.size(); i++) begin
         tick(tv[i].vld, tv[i].code);
         check_all($sformatf("vec%0d", i), tv[i].value, tv[i].upd, tv[i].ch, tv[i].al,
                   tv[i].gas, tv[i].swr, tv[i].err, tv[i].busy);
      end

      // timeout: Enter then TO idle cycles
      tick(1, 8'h5A);
      for (int i = 1; i < TO; i++) begin
         tick(0, 8'h00);
         chk($sformatf("to_wait%0d.busy", i), 32'(busy), 32'd1);
         chk($sformatf("to_wait%0d.err", i), 32'(err), 32'd0);
      end
      tick(0, 8'h00);
      chk("to_fire.err", 32'(err), 32'd1);
      chk("to_fire.busy", 32'(busy), 32'd0);
      tick(0, 8'h00);
      chk("to_after.err", 32'(err), 32'd0);

      // a code on the terminal-count cycle is processed, no timeout
      tick(1, 8'h5A);
      for (int i = 1; i < TO; i++) tick(0, 8'h00);
      tick(1, 8'h16);
      chk("to_tc_code.err", 32'(err), 32'd0);
      chk("to_tc_code.busy", 32'(busy), 32'd1);
      tick(1, 8'h76);
      check_model("to_esc");

      // asynchronous reset between digits
      tick(1, 8'h5A);
      tick(1, 8'h1E);
      tick(1, 8'h16);
      chk("arst_pre.value", 32'(value), 32'h3409);
      #2;
      RST_N = 1'b0;
      #1;
      check_all("arst_now", '0, 0, 4'd0, 2'd0, 0, 0, 0, 0);
      model_reset();
      @(negedge CLK);
      check_all("arst_hold", '0, 0, 4'd0, 2'd0, 0, 0, 0, 0);
      RST_N = 1'b1;
      tick(1, 8'h26);
      check_all("arst_resume", '0, 0, 4'd0, 2'd0, 0, 0, 0, 0);

      // randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 49) == 0) begin
            int gap;
            gap = int'($urandom_range(8, 12));
            for (int g = 0; g < gap; g++) begin
               tick(0, 8'h00);
               check_model($sformatf("rnd%0d.gap%0d", n, g));
            end
         end else begin
            rv = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) rc = 8'($urandom_range(0, 255));
            else rc = pool[$urandom_range(0, 24)];
            tick(rv, rc);
            check_model($sformatf("rnd%0d", n));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/kbd_cmd_decoder.md
KBD_CMD_DECODER -- requirements
Module: kbd_cmd_decoder

Interface
REQ-001 SHALL have parameter NCH, default 2, number of setpoint channels (1..9).
REQ-002 SHALL have parameter NDIG, default 2, BCD digits per setpoint (1..4).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000, idle cycles before an open command aborts.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock.
REQ-005 SHALL have RST_N  in  1  asynchronous active-low reset.
REQ-006 SHALL have code_valid  in  1  one-cycle strobe, code is valid.
REQ-007 SHALL have code  in  8  PS/2 set-2 scancode byte.
REQ-008 SHALL have value  out  NCH*NDIG*4  packed BCD setpoints; channel 0 in the LSBs, most significant digit first within each channel.
REQ-009 SHALL have value_upd  out  1  one-cycle pulse on setpoint commit.
REQ-010 SHALL have value_ch  out  4  channel index of the last commit.
REQ-011 SHALL have alarm_level  out  2  00 none, 01 alert, 10 danger.
REQ-012 SHALL have gas_en  out  1  gas-sensor enable.
REQ-013 SHALL have sw_reset  out  1  one-cycle pulse on the reset key.
REQ-014 SHALL have err  out  1  one-cycle pulse on an invalid key or a timeout.
REQ-015 SHALL have busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL recognise these keys: Enter 0x5A, R 0x2D, H 0x33, A 0x1C, P 0x4D, G 0x34, Y 0x35, N 0x31, Esc 0x76; digits 0-9 are 45,16,1E,26,25,2E,36,3D,3E,46.
REQ-017 SHALL drop the byte following 0xF0 (key release); the 0xE0 prefix is dropped and does not affect the following byte.
REQ-018 SHALL implement states IDLE, CH_SEL, DIGIT, H_SEL, G_SEL.
REQ-019 From IDLE: Enter -> CH_SEL; H -> H_SEL; G -> G_SEL; any other key is ignored with no err.
REQ-020 In CH_SEL: digit d with 1<=d<=NCH selects channel d-1 -> DIGIT; any other key -> err, IDLE.
REQ-021 In DIGIT: each digit shifts into a staging register; the NDIG-th digit commits staging to the selected channel -> IDLE.
REQ-022 In DIGIT: a non-digit key -> err, IDLE, staging discarded, value unchanged.
REQ-023 In H_SEL: A sets alarm_level=01; P sets alarm_level=10; either -> IDLE; other keys -> err, IDLE.
REQ-024 In G_SEL: Y sets gas_en=1; N sets gas_en=0; either -> IDLE; other keys -> err, IDLE.
REQ-025 R in any state SHALL pulse sw_reset, clear alarm_level and gas_en, discard staging and go to IDLE; value SHALL be retained.
REQ-026 Esc in any non-IDLE state SHALL return to IDLE with no err.
REQ-027 All outputs SHALL be registered and SHALL update in the cycle after the code_valid cycle; value_upd and the value change SHALL be coincident.
REQ-028 The timeout counter SHALL reload on every code_valid and count only while busy; terminal count SHALL raise err and go to IDLE.
REQ-029 If code_valid coincides with terminal count, the code SHALL be processed and the timeout SHALL be suppressed.
REQ-030 Each channel's commit SHALL write only that channel's NDIG*4 bits.

Reset
REQ-031 RST_N low SHALL immediately force: state IDLE, value all 0, value_ch 0, alarm_level 00, gas_en 0, all pulses 0, break flag 0, staging 0, timeout counter reloaded.
REQ-032 Reset mid-command SHALL discard the partial command; operation resumes from the first rising CLK edge after RST_N goes high.

Structure
REQ-033 Scancode constants, the state enum and a scancode-to-BCD decode function (with a valid flag) SHALL live in shared package kbd_pkg.
REQ-034 The timeout counter SHALL be sub-module kbd_timeout (load, enable, terminal-count output, counter width $clog2(TIMEOUT_CYC+1)).

Verification
REQ-035 The bench SHALL check a commit: Enter,1E,26,25 (NCH=2) -> value[15:8]=0x34, value_upd for one cycle, value_ch=1.
REQ-036 The bench SHALL check an invalid key: Enter,16,1C -> err pulse, busy=0, value unchanged.
REQ-037 The bench SHALL check break-code filtering: H,F0,33,4D -> alarm_level=10; the 33 after F0 causes no err.
REQ-038 The bench SHALL check the reset key mid-entry: G,35 then Enter,16,1E,2D -> sw_reset pulse, gas_en=0, alarm 00, value unchanged.
REQ-039 The bench SHALL check the timeout (TIMEOUT_CYC=10): Enter then no codes for 10 cycles -> err pulse, busy=0; a code at terminal count -> no err.
REQ-040 The bench SHALL check async reset: assert RST_N between digits -> all outputs 0 immediately, no value_upd.
